delay_seq: RTL and testbench

Sequencer for the sigdelay circular-buffer delay line. It turns a one-cycle sample strobe from the audio front end into wr/rd pulses for the datapath. It applies offset changes only between samples and mutes the output until the buffer holds enough history for the selected delay. It sits between the mic sample source and sigdelay, and presents a valid-qualified delayed sample to the output stage.

---
 rtl/delay_seq_if.sv | 26 ++
 rtl/delay_seq.sv | 58 +++++
 tb/tb_delay_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/delay_seq_if.sv
// delay_seq_if: sample/offset controls from the front end and the sigdelay-facing datapath signals
interface delay_seq_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) ();
  logic              en;
  logic              sample_tick;
  logic              freeze;
  logic [ADDR_W-1:0] offset_req;
  logic              offset_load;
  logic [DATA_W-1:0] dly_in;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] dly_out;
  logic              dly_valid;
  logic              overrun;
  modport master (
    output en, sample_tick, freeze, offset_req, offset_load, dly_in,
    input  wr, rd, offset, dly_out, dly_valid, overrun
  );
  modport slave (
    input  en, sample_tick, freeze, offset_req, offset_load, dly_in,
    output wr, rd, offset, dly_out, dly_valid, overrun
  );
endinterface

// File: rtl/delay_seq.sv
// delay_seq: turns sample strobes into sigdelay wr/rd pulses, applies offsets between samples, mutes until history suffices
module delay_seq #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int DEF_OFFSET = 64,
  parameter int MUTE       = 2**(DATA_W-1)
) (
  input logic        clk,
  input logic        rst,
  delay_seq_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [ADDR_W-1:0] FMAX = '1;
  logic [1:0]        state, state_n;
  logic              s1, s2, pend, busy, acc, cpy;
  logic [ADDR_W-1:0] fill, fill_n, pending, offset_n;
  always_comb begin
    busy     = s1 | s2;
    acc      = bus.en && state != IDLE && bus.sample_tick && !busy;
    cpy      = pend && !busy && !acc;
    offset_n = cpy ? pending : bus.offset;
    fill_n   = (acc && !bus.freeze && fill != FMAX) ? fill + ADDR_W'(1) : fill;
    // the mute decision uses the post-increment fill and the offset taking effect this edge
    state_n  = !bus.en ? IDLE : state == IDLE ? PRIME : (fill_n >= offset_n) ? RUN : PRIME;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      pend          <= 1'b0;
      pending       <= ADDR_W'(DEF_OFFSET);
      fill          <= '0;
      bus.wr        <= 1'b0;
      bus.rd        <= 1'b0;
      bus.offset    <= ADDR_W'(DEF_OFFSET);
      bus.dly_out   <= DATA_W'(MUTE);
      bus.dly_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state         <= state_n;
      fill          <= (bus.en && state != IDLE) ? fill_n : '0;
      s1            <= acc;
      s2            <= s1 && bus.en;
      bus.wr        <= acc && !bus.freeze;
      bus.rd        <= acc;
      bus.dly_valid <= s2 && bus.en;
      bus.dly_out   <= (!bus.en || state == IDLE) ? DATA_W'(MUTE) :
                       s2 ? ((state == RUN) ? bus.dly_in : DATA_W'(MUTE)) : bus.dly_out;
      bus.offset    <= offset_n;
      pending       <= bus.offset_load ? ((bus.offset_req == '0) ? ADDR_W'(1) : bus.offset_req) : pending;
      pend          <= bus.offset_load || (pend && !cpy);
      bus.overrun   <= bus.en && (bus.overrun || (bus.sample_tick && busy && state != IDLE));
    end
  end
endmodule

// File: tb/tb_delay_seq.sv
// tb_delay_seq: directed checks of delay_seq against a behavioural sigdelay RAM
module tb_delay_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  delay_seq_if #(.ADDR_W(9), .DATA_W(8)) bus ();
  delay_seq dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] mem [512] = '{default: 8'd0};
  logic [8:0] wp;
  logic [7:0] din;
  int n_chk = 0, n_fail = 0, wc = 0, base = 0;
  always @(posedge clk) begin
    if (rst) wp <= '0;
    else begin
      if (bus.wr) begin
        mem[wp] <= din;
        wp <= wp + 9'd1;
      end
      if (bus.rd) bus.dly_in <= mem[wp - bus.offset];
    end
  end
  function automatic logic [7:0] f(input int j);
    return (j < 0) ? 8'd0 : 8'(j + 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic frz, input logic [7:0] exp, input logic [8:0] off,
                      input logic ld, input logic [8:0] req);
    bus.sample_tick = 1'b1;
    bus.freeze = frz;
    din = 8'(wc + 1);
    bus.offset_load = ld;
    bus.offset_req = req;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.offset_load = 1'b0;
    chk("wr", bus.wr, !frz);
    chk("rd", bus.rd, 1);
    chk("offset_e0", bus.offset, off);
    @(negedge clk);
    bus.freeze = 1'b0;
    chk("wr_rd_end", bus.wr | bus.rd, 0);
    chk("early_valid", bus.dly_valid, 0);
    @(negedge clk);
    chk("valid", bus.dly_valid, 1);
    chk("dly_out", bus.dly_out, exp);
    chk("offset_e2", bus.offset, off);
    if (!frz) wc++;
  endtask
  task automatic run(input int n, input int off, input int gap);
    int fa;
    for (int i = 0; i < n; i++) begin
      fa = (wc - base + 1 > 511) ? 511 : wc - base + 1;
      tick(1'b0, (fa < off) ? 8'd128 : f(wc - off), 9'(off), 1'b0, 9'd0);
      repeat (gap) @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.sample_tick = 1'b0;
    bus.freeze = 1'b0;
    bus.offset_load = 1'b0;
    bus.offset_req = '0;
    din = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr", bus.wr, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_valid", bus.dly_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_offset", bus.offset, 64);
    chk("rst_dly_out", bus.dly_out, 128);
    rst = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);
    run(100, 64, 7);
    // offset request rides along with a tick: that tick still uses 64
    tick(1'b0, f(wc - 64), 9'd64, 1'b1, 9'd200);
    @(negedge clk);
    chk("offset_200", bus.offset, 200);
    repeat (6) @(negedge clk);
    run(110, 200, 6);
    bus.offset_req = 9'd0;
    bus.offset_load = 1'b1;
    @(negedge clk);
    bus.offset_load = 1'b0;
    @(negedge clk);
    chk("offset_clamp", bus.offset, 1);
    run(3, 1, 4);
    bus.sample_tick = 1'b1;
    din = 8'(wc + 1);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("ovr_wr", bus.wr, 1);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("ovr_valid", bus.dly_valid, 1);
    chk("ovr_out", bus.dly_out, f(wc - 1));
    chk("ovr_drop", bus.wr | bus.rd, 0);
    chk("ovr_flag", bus.overrun, 1);
    wc++;
    @(negedge clk);
    chk("ovr_drop_late", bus.wr | bus.rd, 0);
    repeat (3) @(negedge clk);
    run(1, 1, 4);
    chk("ovr_sticky", bus.overrun, 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("ovr_clear", bus.overrun, 0);
    chk("idle_mute", bus.dly_out, 128);
    bus.en = 1'b1;
    @(negedge clk);
    base = wc;
    run(2, 1, 4);
    repeat (5) begin
      tick(1'b1, f(wc - 1), 9'd1, 1'b0, 9'd0);
      repeat (4) @(negedge clk);
    end
    run(2, 1, 4);
    bus.en = 1'b0;
    @(negedge clk);
    bus.offset_req = 9'd511;
    bus.offset_load = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    bus.offset_load = 1'b0;
    @(negedge clk);
    chk("offset_511", bus.offset, 511);
    base = wc;
    run(515, 511, 1);
    bus.sample_tick = 1'b1;
    din = 8'(wc + 1);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("abort_en_wr", bus.wr, 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("abort_en_idle", bus.wr | bus.rd, 0);
    @(negedge clk);
    chk("abort_en_valid", bus.dly_valid, 0);
    chk("abort_en_mute", bus.dly_out, 128);
    @(negedge clk);
    chk("abort_en_valid2", bus.dly_valid, 0);
    bus.en = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("abort_rst_rd", bus.rd, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_valid", bus.dly_valid, 0);
    chk("abort_rst_mute", bus.dly_out, 128);
    chk("abort_rst_offset", bus.offset, 64);
    chk("abort_rst_wr_rd", bus.wr | bus.rd, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rst_valid2", bus.dly_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
